// File: rtl/mfp_reset_requester_if.sv
// Register-access and reset-handshake bundle for mfp_reset_requester.
// Ports: wr_en/addr/wdata (register writes), rdata (registered read data),
//        si_reset (from the reset generator), rst_req/wdt_expired/busy (status).
// The master side is the software/reset-generator environment and the slave side is the requester.
interface mfp_reset_requester_if;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        si_reset;
  logic        rst_req;
  logic        wdt_expired;
  logic        busy;

  modport master (
    output wr_en, addr, wdata, si_reset,
    input  rdata, rst_req, wdt_expired, busy
  );

  modport slave (
    input  wr_en, addr, wdata, si_reset,
    output rdata, rst_req, wdt_expired, busy
  );
endinterface

// File: rtl/mfp_reset_requester.sv
// Watchdog plus software soft-reset requester with a rst_req/si_reset handshake and a reset-cause register.
// Latency: rst_req rises 1 cycle after the REQ decision; rdata is valid 1 cycle after addr; wdt_expired is combinational.
// Backpressure: none. Writes are always accepted; sw_req and KICK writes are dropped while busy.
// Ports: clk, resetn (async active-low), bus (slave modport: wr_en/addr/wdata in, rdata out,
//        si_reset in, rst_req/wdt_expired/busy out).
module mfp_reset_requester #(
  parameter int          CNT_WIDTH   = 32,
  parameter int          MIN_PULSE   = 4,
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [31:0] KICK_KEY    = 32'hA5C3_0F96
) (
  input logic                  clk,
  input logic                  resetn,
  mfp_reset_requester_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_KICK   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  localparam int PW = $clog2(ACK_TIMEOUT + 1);

  logic [1:0]           r_state;
  logic                 r_wdt_en;
  logic [CNT_WIDTH-1:0] r_load;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_cause_wdt;
  logic                 r_cause_sw;
  logic                 r_ack_err;
  logic [PW-1:0]        r_pulse;
  logic                 r_rst_req;
  logic                 r_fold_exp;
  logic [31:0]          r_rdata;

  logic [1:0]  w_state_nxt;
  logic        w_idle;
  logic        w_busy;
  logic        w_wr_ctrl;
  logic        w_wr_load;
  logic        w_wr_kick;
  logic        w_wr_status;
  logic        w_en_rise;
  logic        w_sw_trig;
  logic        w_kick;
  logic        w_wdt_hit;
  logic        w_wdt_fold;
  logic        w_enter_req;
  logic        w_pulse_ok;
  logic        w_timeout;
  logic        w_to_hold;
  logic        w_ack_fail;
  logic [31:0] w_load_ext;
  logic [31:0] w_rdata_nxt;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_busy      = !w_idle;

  assign w_wr_ctrl   = bus.wr_en && (bus.addr == A_CTRL);
  assign w_wr_load   = bus.wr_en && (bus.addr == A_LOAD);
  assign w_wr_kick   = bus.wr_en && (bus.addr == A_KICK);
  assign w_wr_status = bus.wr_en && (bus.addr == A_STATUS);

  assign w_en_rise   = w_wr_ctrl && bus.wdata[0] && !r_wdt_en;
  assign w_sw_trig   = w_wr_ctrl && bus.wdata[1] && w_idle;
  assign w_kick      = w_wr_kick && (bus.wdata == KICK_KEY) && w_idle;

  assign w_wdt_hit   = w_idle && r_wdt_en && (r_cnt == '0);
  // Enable and sw_req in one write with LOAD=0: the watchdog would expire on the
  // very cycle REQ is entered, so fold it into the same request and report it then.
  assign w_wdt_fold  = w_sw_trig && w_en_rise && (r_load == '0);
  assign w_enter_req = w_wdt_hit || w_sw_trig;

  assign w_pulse_ok  = (r_pulse >= PW'(MIN_PULSE - 1));
  assign w_timeout   = (r_pulse == PW'(ACK_TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_enter_req) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.si_reset && w_pulse_ok) w_state_nxt = ST_HOLD;
        else if (w_timeout)             w_state_nxt = ST_IDLE;
      end
      ST_HOLD: if (!bus.si_reset) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_to_hold  = (r_state == ST_REQ) && (w_state_nxt == ST_HOLD);
  assign w_ack_fail = (r_state == ST_REQ) && (w_state_nxt == ST_IDLE);

  always_comb begin
    w_load_ext = '0;
    w_load_ext[CNT_WIDTH-1:0] = r_load;
  end

  always_comb begin
    w_rdata_nxt = '0;
    case (bus.addr)
      A_CTRL:   w_rdata_nxt[0]   = r_wdt_en;
      A_LOAD:   w_rdata_nxt      = w_load_ext;
      A_KICK:   w_rdata_nxt      = '0;
      A_STATUS: w_rdata_nxt[3:0] = {w_busy, r_ack_err, r_cause_sw, r_cause_wdt};
      default:  w_rdata_nxt      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_wdt_en    <= 1'b0;
      r_load      <= '1;
      r_cnt       <= '1;
      r_cause_wdt <= 1'b0;
      r_cause_sw  <= 1'b0;
      r_ack_err   <= 1'b0;
      r_pulse     <= '0;
      r_rst_req   <= 1'b0;
      r_fold_exp  <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_req  <= (w_state_nxt == ST_REQ);
      r_fold_exp <= w_wdt_fold;
      r_rdata    <= w_rdata_nxt;

      // Counts cycles spent in REQ; restarts at zero on every REQ entry.
      if ((r_state == ST_REQ) && (w_state_nxt == ST_REQ)) r_pulse <= r_pulse + 1'b1;
      else                                                r_pulse <= '0;

      // HOLD entry disarms the watchdog so the rebooted system starts quiet.
      if (w_to_hold)      r_wdt_en <= 1'b0;
      else if (w_wr_ctrl) r_wdt_en <= bus.wdata[0];

      if (w_wr_load) r_load <= bus.wdata[CNT_WIDTH-1:0];

      // Counter only moves in IDLE and stops at zero; a reload wins over a decrement.
      if (w_en_rise || w_kick)                    r_cnt <= r_load;
      else if (w_idle && r_wdt_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;

      // Sticky cause bits: a new event in the same cycle beats a clear.
      if (w_wdt_hit || w_wdt_fold)           r_cause_wdt <= 1'b1;
      else if (w_wr_status && bus.wdata[0])  r_cause_wdt <= 1'b0;

      if (w_sw_trig)                         r_cause_sw <= 1'b1;
      else if (w_wr_status && bus.wdata[1])  r_cause_sw <= 1'b0;

      if (w_ack_fail)                        r_ack_err <= 1'b1;
      else if (w_wr_status && bus.wdata[2])  r_ack_err <= 1'b0;
    end
  end

  assign bus.rst_req     = r_rst_req;
  assign bus.wdt_expired = w_wdt_hit || r_fold_exp;
  assign bus.busy        = w_busy;
  assign bus.rdata       = r_rdata;

endmodule

// File: tb/tb_mfp_reset_requester.sv
module tb_mfp_reset_requester;

  localparam int          MIN_PULSE   = 4;
  localparam int          ACK_TIMEOUT = 255;
  localparam logic [31:0] KEY         = 32'hA5C3_0F96;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  mfp_reset_requester_if bus();

  mfp_reset_requester #(
    .CNT_WIDTH  (32),
    .MIN_PULSE  (MIN_PULSE),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .KICK_KEY   (KEY)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.wr_en = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    tick();
    d = bus.rdata;
  endtask

  // Reference model of one request: si_reset is high for cycles [d, d+len) counted
  // from the first rst_req cycle. The generator is acknowledged at the first cycle
  // p >= MIN_PULSE-1 where si_reset is high; otherwise the request times out.
  task automatic model_req(input int d, input int len, output int hi, output int bf, output bit ack_err);
    int p;
    p = (d > MIN_PULSE - 1) ? d : MIN_PULSE - 1;
    if (len > 0 && p < d + len && p <= ACK_TIMEOUT) begin
      hi = p + 1;
      bf = d + len + 1;
      ack_err = 1'b0;
    end else begin
      hi = ACK_TIMEOUT + 1;
      bf = ACK_TIMEOUT + 1;
      ack_err = 1'b1;
    end
  endtask

  // Called in the first cycle rst_req is high. Drives si_reset, counts rst_req-high
  // cycles, finds when busy drops, samples STATUS during REQ, counts expiry pulses.
  task automatic req_cycle(input string tag, input int d, input int len,
                           input logic [31:0] exp_st, input int exp_pulses);
    int hi, bf, pulses, e_hi, e_bf;
    bit e_ack;
    logic [31:0] st;
    model_req(d, len, e_hi, e_bf, e_ack);
    hi = 0; bf = -1; pulses = 0; st = '0;
    bus.addr = 2'd3;
    for (int t = 0; t < 400; t++) begin
      if (t == 1) st = bus.rdata;
      if (bus.rst_req === 1'b1) hi++;
      if (bus.wdt_expired === 1'b1) pulses++;
      if (bus.busy === 1'b0 && bf < 0) bf = t;
      if (bf >= 0 && t >= d + len + 1) break;
      bus.si_reset = (t >= d && t < d + len);
      tick();
    end
    bus.si_reset = 1'b0;
    chk({tag, "_rst_req_cycles"}, hi, e_hi);
    chk({tag, "_busy_fall"}, bf, e_bf);
    chk({tag, "_status_in_req"}, st, exp_st);
    chk({tag, "_expiry_pulses"}, pulses, exp_pulses);
    rd(2'd3, st);
    chk({tag, "_ack_err"}, st[2], e_ack);
  endtask

  initial begin
    logic [31:0] v;
    int n, k, ld, d, len;
    n_tests = 0;
    n_fail  = 0;
    resetn = 1'b0;
    bus.wr_en = 1'b0; bus.addr = '0; bus.wdata = '0; bus.si_reset = 1'b0;
    tick(); tick();
    chk("reset_rst_req", bus.rst_req, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_wdt_expired", bus.wdt_expired, 1'b0);
    chk("reset_rdata", bus.rdata, 32'h0);
    resetn = 1'b1;
    tick();
    rd(2'd0, v); chk("reset_ctrl", v, 32'h0);
    rd(2'd1, v); chk("reset_load", v, 32'hFFFF_FFFF);
    rd(2'd2, v); chk("reset_kick", v, 32'h0);
    rd(2'd3, v); chk("reset_status", v, 32'h0);

    // si_reset from another source while idle changes nothing.
    bus.si_reset = 1'b1;
    repeat (5) tick();
    chk("idle_si_busy", bus.busy, 1'b0);
    chk("idle_si_rst_req", bus.rst_req, 1'b0);
    bus.si_reset = 1'b0;
    rd(2'd3, v); chk("idle_si_status", v, 32'h0);

    // Watchdog expiry: LOAD+1 cycles after enable write.
    for (int i = 0; i < 2; i++) begin
      ld = (i == 0) ? 10 : $urandom_range(1, 60);
      wr(2'd1, ld);
      rd(2'd1, v); chk("wdt_load_rb", v, ld);
      wr(2'd0, 32'h1);
      n = 1;
      while (bus.wdt_expired !== 1'b1 && n < 300) begin tick(); n++; end
      chk("wdt_expiry_latency", n, ld + 1);
      chk("wdt_no_req_yet", bus.rst_req, 1'b0);
      tick();
      chk("wdt_rst_req_rise", bus.rst_req, 1'b1);
      chk("wdt_pulse_width", bus.wdt_expired, 1'b0);
      d = $urandom_range(0, 8); len = $urandom_range(4, 10);
      req_cycle("wdt", d, len, 32'h9, 0);
      rd(2'd3, v); chk("wdt_status_after", v, 32'h1);
      rd(2'd0, v); chk("wdt_en_cleared", v, 32'h0);
      wr(2'd3, 32'h7);
      rd(2'd3, v); chk("wdt_status_clr", v, 32'h0);
    end

    // Kicks hold off the watchdog; a wrong key does not.
    for (int i = 0; i < 2; i++) begin
      k = (i == 0) ? 15 : $urandom_range(10, 20);
      wr(2'd1, 32'd20);
      wr(2'd0, 32'h1);
      n = 0;
      for (int j = 0; j < 5; j++) begin
        wr(2'd2, KEY);
        if (bus.wdt_expired === 1'b1) n++;
        repeat (k - 1) begin
          tick();
          if (bus.wdt_expired === 1'b1) n++;
        end
      end
      chk("kick_no_expiry", n, 0);
      v = (i == 0) ? 32'h0 : ($urandom | 32'h1) ^ KEY;
      wr(2'd2, v);
      n = k + 1;
      while (bus.wdt_expired !== 1'b1 && n < 300) begin tick(); n++; end
      chk("kick_expiry_after_last", n, 21);
      tick();
      req_cycle("kick", $urandom_range(0, 8), $urandom_range(4, 10), 32'h9, 0);
      wr(2'd3, 32'h7);
    end

    // Software request with the watchdog armed; HOLD disarms it.
    for (int i = 0; i < 3; i++) begin
      d   = (i == 0) ? 2 : $urandom_range(0, 8);
      len = (i == 0) ? 8 : $urandom_range(4, 10);
      wr(2'd1, 32'd5000);
      wr(2'd0, 32'h1);
      wr(2'd0, 32'h3);
      chk("sw_rst_req_rise", bus.rst_req, 1'b1);
      req_cycle("sw", d, len, 32'hA, 0);
      rd(2'd3, v); chk("sw_status_after", v, 32'h2);
      rd(2'd0, v); chk("sw_wdt_en_cleared", v, 32'h0);
      wr(2'd3, 32'h7);
    end

    // No acknowledge: timeout after ACK_TIMEOUT+1 cycles of rst_req.
    wr(2'd0, 32'h2);
    chk("to_rst_req_rise", bus.rst_req, 1'b1);
    req_cycle("timeout", 1000, 0, 32'hA, 0);
    chk("to_rst_req_low", bus.rst_req, 1'b0);
    chk("to_busy_low", bus.busy, 1'b0);
    rd(2'd3, v); chk("to_status", v, 32'h6);
    wr(2'd3, 32'h7);
    rd(2'd3, v); chk("to_status_clr", v, 32'h0);

    // LOAD=0 with enable and sw_req in one write: one request, both causes.
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h3);
    chk("both_rst_req_rise", bus.rst_req, 1'b1);
    req_cycle("both", $urandom_range(0, 8), $urandom_range(4, 10), 32'hB, 1);
    rd(2'd3, v); chk("both_status_after", v, 32'h3);
    wr(2'd3, 32'h7);

    // Asynchronous reset in the middle of REQ.
    wr(2'd1, 32'd5000);
    wr(2'd0, 32'h1);
    wr(2'd0, 32'h3);
    tick(); tick();
    chk("arst_pre_rst_req", bus.rst_req, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_rst_req_async", bus.rst_req, 1'b0);
    chk("arst_busy_async", bus.busy, 1'b0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    rd(2'd0, v); chk("arst_ctrl", v, 32'h0);
    rd(2'd1, v); chk("arst_load", v, 32'hFFFF_FFFF);
    rd(2'd3, v); chk("arst_status", v, 32'h0);
    chk("arst_rst_req_after", bus.rst_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
